control_pipe_n: RTL and testbench
=================================

// Module: control_pipe_n
// PURPOSE
//   Parametrised successor of the pipelined control unit. Sits in DECODE:
//   - decodes opcode/funct into a control word;
//   - carries that word down a post-decode pipe: EXEC, then MEM_STAGES memory stages, then WRITEBACK.
//   - Adds over the previous generation: a configurable memory depth, a flush input,
//     per-stage valid bits, destination-register tracking, JAL writing $31, and SLT/NOR ALU ops.
// PARAMETERS
//   MEM_STAGES  1  number of memory stages, legal range 1..4; NST = MEM_STAGES+2 post-decode stages
//   OPW         4  ALU op width; must be >= 4
// PORTS
//   clk         in   1         clock, rising edge
//   rst         in   1         asynchronous, active-high reset
//   opcode      in   6         instr[31:26] in DECODE
//   funct       in   6         instr[5:0] in DECODE
//   rt, rd      in   5 each    instr[20:16], instr[15:11] in DECODE
//   zero        in   1         register-compare equal flag in DECODE
//   stall       in   1         insert a bubble into EXEC; older stages keep advancing
//   flush       in   1         kill the instruction entering EXEC (wrong-path instruction)
//   stop        in   1         freeze every pipe register
//   jbeq,j,jal,jr out 1 each   DECODE-stage branch/jump controls (combinational)
//   shift,srl,ri  out 1 each   EXEC-stage controls
//   op          out  OPW       EXEC-stage ALU op
//   write_mem   out  1         store strobe; first memory stage only
//   read_mem    out  1         load strobe; first memory stage only
//   write_reg   out  1         WRITEBACK register-file write enable
//   lw          out  1         WRITEBACK: select memory data
//   wb_dst      out  5         WRITEBACK destination register
//   st_wreg     out  NST       per-stage write_reg & valid; index 0 = EXEC, NST-1 = WB
//   st_lw       out  NST       per-stage load & valid
//   st_dst      out  5*NST     per-stage destination; stage i at [5i+4:5i]
// BEHAVIOUR
//   Decode:
//   - BEQ 000100, BNE 000101, R-type 000000, LW 100011, SW 101011, J 000010, JAL 000011.
//   - jbeq = BEQ&zero | BNE&~zero.
//   - jr = R-type & funct==001000.
//   - ri = ~(R-type|BEQ|BNE).
//   - shift = R-type & funct in {000000, 000010}; srl = shift & funct==000010.
//   - write_reg_d = ~(BEQ|BNE|SW|J|JR).
//   - dst = JAL ? 31 : R-type ? rd : rt.
//   - A write to $0 clears write_reg_d.
//   ALU op (zero-extended to OPW):
//   - ADD/ADDI/LW/SW = 0
//   - SUB/BEQ/BNE = 1
//   - AND/ANDI = 2
//   - OR/ORI = 3
//   - XOR/XORI = 4
//   - SLT/SLTI = 5
//   - NOR = 6
//   - anything else = 0
//   Pipe word per stage: {valid, write_reg, lw, write_mem, dst, shift, srl, ri, op}.
//   - Decode always loads valid = 1.
//   - A bubble is the all-zero word.
//   Clocking (priority order):
//   - rst asserted: all stages zero immediately (asynchronous), so every stage output reads 0.
//   - else stop: every stage holds its value; stop overrides stall and flush.
//   - else: EXEC <= (stall|flush) ? 0 : decoded word; stage i+1 <= stage i.
//   - stall & flush together: one bubble.
//   Latency: decode -> EXEC 1 cycle; first memory stage 2; WRITEBACK MEM_STAGES+2.
//   Outputs:
//   - Every registered output is gated by its stage valid bit.
//   - jbeq/j/jal/jr are ungated combinational decode (stall and flush are ignored here).
//   - write_mem/read_mem assert only in memory stage 0, for exactly one cycle per instruction
//     (longer only while stop holds the pipe).
//   - Later memory stages only forward the word.
//   Reset release mid-operation: the pipe restarts empty; no partially flushed state survives.
// STRUCTURE
//   - Package ctrl_pkg: opcode/funct localparams, ALU op codes, ctrl_word_t struct (fields above),
//     CTRL_BUBBLE constant.
//   - Sub-module ctrl_decode: purely combinational opcode/funct/rt/rd/zero -> ctrl_word_t plus
//     jbeq/j/jal/jr.
//   - Top level: a generate loop of NST ctrl_word_t registers with the clocking rules above,
//     and the output fan-out.
// TESTING
//   1 Reset: rst=1 mid-stream with all stages valid -> every output 0 before the next clk edge;
//     after release, outputs stay 0 until the first decoded instruction arrives.
//   2 Latency (MEM_STAGES=1 and 3):
//     - ADD rd=5 issued -> op=0 in EXEC at +1;
//     - write_reg=1, wb_dst=5 at +3 (MEM_STAGES=1) and +5 (MEM_STAGES=3).
//   3 Load/store:
//     - LW rt=7 -> read_mem=1 for one cycle at +2; st_lw[0]=1 at +1;
//     - SW -> write_mem=1 at +2 and write_reg never asserts.
//   4 Bubble:
//     - stall=1 for one cycle on ADD -> EXEC is zero that cycle; the older LW keeps advancing;
//     - flush=1 behaves the same; stall+flush gives a single bubble.
//   5 Stop: stop=1 for 3 cycles with LW in memory stage 0 and ADD in WB
//     -> read_mem and write_reg held at 1 for 3 cycles; stop overrides stall=1.
//   6 Decode corners:
//     - JAL -> jal=1 at +0; write_reg with wb_dst=31 at WB;
//     - BNE with zero=0 -> jbeq=1;
//     - ADD rd=0 -> write_reg stays 0;
//     - SLT -> op=5; NOR -> op=6.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings and the per-stage control word for the parametrised control pipe.
package ctrl_pkg;

    localparam int unsigned CTRL_OPW = 4;
    localparam int unsigned REGW     = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [REGW-1:0] REG_RA = 5'd31;

    localparam logic [CTRL_OPW-1:0] ALU_ADD = 4'd0;
    localparam logic [CTRL_OPW-1:0] ALU_SUB = 4'd1;
    localparam logic [CTRL_OPW-1:0] ALU_AND = 4'd2;
    localparam logic [CTRL_OPW-1:0] ALU_OR  = 4'd3;
    localparam logic [CTRL_OPW-1:0] ALU_XOR = 4'd4;
    localparam logic [CTRL_OPW-1:0] ALU_SLT = 4'd5;
    localparam logic [CTRL_OPW-1:0] ALU_NOR = 4'd6;

    typedef struct packed {
        logic                valid;
        logic                write_reg;
        logic                lw;
        logic                write_mem;
        logic [REGW-1:0]     dst;
        logic                shift;
        logic                srl;
        logic                ri;
        logic [CTRL_OPW-1:0] op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

    // ALU op from opcode/funct; unlisted encodings fall back to add.
    function automatic logic [CTRL_OPW-1:0] alu_op(input logic [5:0] opcode,
                                                   input logic [5:0] funct);
        logic [CTRL_OPW-1:0] res;
        res = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  res = ALU_ADD;
                FN_SUB:  res = ALU_SUB;
                FN_AND:  res = ALU_AND;
                FN_OR:   res = ALU_OR;
                FN_XOR:  res = ALU_XOR;
                FN_SLT:  res = ALU_SLT;
                FN_NOR:  res = ALU_NOR;
                default: res = ALU_ADD;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_LW, OP_SW: res = ALU_ADD;
                OP_BEQ, OP_BNE:        res = ALU_SUB;
                OP_ANDI:               res = ALU_AND;
                OP_ORI:                res = ALU_OR;
                OP_XORI:               res = ALU_XOR;
                OP_SLTI:               res = ALU_SLT;
                default:               res = ALU_ADD;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational DECODE: instruction fields to a pipe control word plus branch/jump controls.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    input  logic            zero,
    output ctrl_word_t      word,
    output logic            jbeq,
    output logic            j,
    output logic            jal,
    output logic            jr
);

    logic is_r;
    logic is_beq;
    logic is_bne;
    logic is_sw;

    always_comb begin
        is_r   = (opcode == OP_RTYPE);
        is_beq = (opcode == OP_BEQ);
        is_bne = (opcode == OP_BNE);
        is_sw  = (opcode == OP_SW);
        j      = (opcode == OP_J);
        jal    = (opcode == OP_JAL);
        jr     = is_r & (funct == FN_JR);
        jbeq   = (is_beq & zero) | (is_bne & ~zero);

        word           = CTRL_BUBBLE;
        word.valid     = 1'b1;
        word.lw        = (opcode == OP_LW);
        word.write_mem = is_sw;
        word.shift     = is_r & ((funct == FN_SLL) | (funct == FN_SRL));
        word.srl       = is_r & (funct == FN_SRL);
        word.ri        = ~(is_r | is_beq | is_bne);
        word.op        = alu_op(opcode, funct);

        if (jal)       word.dst = REG_RA;
        else if (is_r) word.dst = rd;
        else           word.dst = rt;

        // $0 is hardwired, so a write to it is dropped at decode.
        word.write_reg = ~(is_beq | is_bne | is_sw | j | jr) & (word.dst != '0);
    end

endmodule

// File: rtl/control_pipe_n.sv
// Pipelined control unit: decode, then EXEC, MEM_STAGES memory stages and WRITEBACK.
module control_pipe_n
    import ctrl_pkg::*;
#(
    parameter  int unsigned MEM_STAGES = 1,
    parameter  int unsigned OPW        = 4,
    localparam int unsigned NST        = MEM_STAGES + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              zero,
    input  logic              stall,
    input  logic              flush,
    input  logic              stop,
    output logic              jbeq,
    output logic              j,
    output logic              jal,
    output logic              jr,
    output logic              shift,
    output logic              srl,
    output logic              ri,
    output logic [OPW-1:0]    op,
    output logic              write_mem,
    output logic              read_mem,
    output logic              write_reg,
    output logic              lw,
    output logic [4:0]        wb_dst,
    output logic [NST-1:0]    st_wreg,
    output logic [NST-1:0]    st_lw,
    output logic [5*NST-1:0]  st_dst
);

    ctrl_word_t           dec_word;
    ctrl_word_t [NST-1:0] pipe_q;

    ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .rt     (rt),
        .rd     (rd),
        .zero   (zero),
        .word   (dec_word),
        .jbeq   (jbeq),
        .j      (j),
        .jal    (jal),
        .jr     (jr)
    );

    // Stage 0 is EXEC, stage NST-1 is WRITEBACK; stop freezes every stage.
    for (genvar g = 0; g < NST; g++) begin : g_stage
        ctrl_word_t q;
        ctrl_word_t d;

        if (g == 0) begin : g_exec
            assign d = (stall | flush) ? CTRL_BUBBLE : dec_word;
        end else begin : g_fwd
            assign d = pipe_q[g-1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)        q <= CTRL_BUBBLE;
            else if (!stop) q <= d;
        end

        assign pipe_q[g]              = q;
        assign st_wreg[g]             = q.valid & q.write_reg;
        assign st_lw[g]               = q.valid & q.lw;
        assign st_dst[REGW*g +: REGW] = q.valid ? q.dst : '0;
    end

    assign shift     = pipe_q[0].valid & pipe_q[0].shift;
    assign srl       = pipe_q[0].valid & pipe_q[0].srl;
    assign ri        = pipe_q[0].valid & pipe_q[0].ri;
    assign op        = pipe_q[0].valid ? OPW'(pipe_q[0].op) : '0;

    assign write_mem = pipe_q[1].valid & pipe_q[1].write_mem;
    assign read_mem  = pipe_q[1].valid & pipe_q[1].lw;

    assign write_reg = pipe_q[NST-1].valid & pipe_q[NST-1].write_reg;
    assign lw        = pipe_q[NST-1].valid & pipe_q[NST-1].lw;
    assign wb_dst    = pipe_q[NST-1].valid ? pipe_q[NST-1].dst : '0;

    // EXEC/MEM-only fields have no consumer once they reach WRITEBACK.
    logic unused_wb;
    assign unused_wb = ^{pipe_q[NST-1].shift, pipe_q[NST-1].srl, pipe_q[NST-1].ri,
                         pipe_q[NST-1].op, pipe_q[NST-1].write_mem};

endmodule

// File: tb/tb_control_pipe_n.sv
// Bench for control_pipe_n: MEM_STAGES=1 and MEM_STAGES=3 instances against an instruction-level model.
module tb_control_pipe_n;

    localparam logic [5:0] OPC_R = 6'd0,  OPC_J = 6'd2,  OPC_JAL = 6'd3,  OPC_BEQ = 6'd4;
    localparam logic [5:0] OPC_BNE = 6'd5, OPC_ADDI = 6'd8, OPC_SLTI = 6'd10, OPC_ANDI = 6'd12;
    localparam logic [5:0] OPC_ORI = 6'd13, OPC_XORI = 6'd14, OPC_LW = 6'd35, OPC_SW = 6'd43;
    localparam logic [5:0] F_SLL = 6'd0, F_SRL = 6'd2, F_JR = 6'd8, F_ADD = 6'd32, F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_XOR = 6'd38, F_NOR = 6'd39, F_SLT = 6'd42;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic [4:0] rt, rd;
    logic       zero, stall, flush, stop;

    logic        jbeq_a, j_a, jal_a, jr_a, shift_a, srl_a, ri_a;
    logic [3:0]  op_a;
    logic        write_mem_a, read_mem_a, write_reg_a, lw_a;
    logic [4:0]  wb_dst_a;
    logic [2:0]  st_wreg_a, st_lw_a;
    logic [14:0] st_dst_a;

    logic        jbeq_b, j_b, jal_b, jr_b, shift_b, srl_b, ri_b;
    logic [5:0]  op_b;
    logic        write_mem_b, read_mem_b, write_reg_b, lw_b;
    logic [4:0]  wb_dst_b;
    logic [4:0]  st_wreg_b, st_lw_b;
    logic [24:0] st_dst_b;

    int n_tests = 0;
    int n_fail  = 0;

    control_pipe_n #(.MEM_STAGES(1), .OPW(4)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt), .rd(rd), .zero(zero),
        .stall(stall), .flush(flush), .stop(stop),
        .jbeq(jbeq_a), .j(j_a), .jal(jal_a), .jr(jr_a), .shift(shift_a), .srl(srl_a), .ri(ri_a),
        .op(op_a), .write_mem(write_mem_a), .read_mem(read_mem_a), .write_reg(write_reg_a),
        .lw(lw_a), .wb_dst(wb_dst_a), .st_wreg(st_wreg_a), .st_lw(st_lw_a), .st_dst(st_dst_a)
    );

    control_pipe_n #(.MEM_STAGES(3), .OPW(6)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt), .rd(rd), .zero(zero),
        .stall(stall), .flush(flush), .stop(stop),
        .jbeq(jbeq_b), .j(j_b), .jal(jal_b), .jr(jr_b), .shift(shift_b), .srl(srl_b), .ri(ri_b),
        .op(op_b), .write_mem(write_mem_b), .read_mem(read_mem_b), .write_reg(write_reg_b),
        .lw(lw_b), .wb_dst(wb_dst_b), .st_wreg(st_wreg_b), .st_lw(st_lw_b), .st_dst(st_dst_b)
    );

    initial forever #5 clk = ~clk;

    // One instruction's view of the pipe; an empty slot is all zero.
    typedef struct {
        bit          v, wr, ld, st, sh, sr, ri;
        bit [4:0]    dst;
        int unsigned op;
    } ref_t;

    ref_t pipe [6];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ref_t ref_decode(input logic [5:0] o, input logic [5:0] f,
                                        input logic [4:0] t, input logic [4:0] d);
        ref_t w;
        bit   is_r;
        w    = '{default: 0};
        is_r = (o == OPC_R);
        w.v  = 1;
        w.ld = (o == OPC_LW);
        w.st = (o == OPC_SW);
        w.sh = is_r && (f == F_SLL || f == F_SRL);
        w.sr = is_r && (f == F_SRL);
        w.ri = !(is_r || o == OPC_BEQ || o == OPC_BNE);
        w.dst = (o == OPC_JAL) ? 5'd31 : (is_r ? d : t);
        w.wr = !(o == OPC_BEQ || o == OPC_BNE || o == OPC_SW || o == OPC_J || (is_r && f == F_JR))
               && (w.dst != 0);
        if (is_r) begin
            case (f)
                F_SUB: w.op = 1;  F_AND: w.op = 2;  F_OR: w.op = 3;
                F_XOR: w.op = 4;  F_SLT: w.op = 5;  F_NOR: w.op = 6;
                default: w.op = 0;
            endcase
        end else begin
            case (o)
                OPC_BEQ, OPC_BNE: w.op = 1;
                OPC_ANDI: w.op = 2;  OPC_ORI: w.op = 3;
                OPC_XORI: w.op = 4;  OPC_SLTI: w.op = 5;
                default: w.op = 0;
            endcase
        end
        return w;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 6; k++) pipe[k] = '{default: 0};
    endtask

    task automatic model_clock();
        if (rst) begin
            model_clear();
        end else if (!stop) begin
            for (int k = 5; k > 0; k--) pipe[k] = pipe[k-1];
            if (stall || flush) pipe[0] = '{default: 0};
            else                pipe[0] = ref_decode(opcode, funct, rt, rd);
        end
    endtask

    task automatic check_all();
        logic [31:0] ew, el, ed;
        bit          bq, bn;
        bq = (opcode == OPC_BEQ);
        bn = (opcode == OPC_BNE);
        chk("jbeq_a", jbeq_a, (bq && zero) || (bn && !zero));
        chk("jbeq_b", jbeq_b, (bq && zero) || (bn && !zero));
        chk("j_a",    j_a,    opcode == OPC_J);
        chk("jal_b",  jal_b,  opcode == OPC_JAL);
        chk("jr_a",   jr_a,   opcode == OPC_R && funct == F_JR);
        chk("shift_a", shift_a, pipe[0].sh);
        chk("srl_b",   srl_b,   pipe[0].sr);
        chk("ri_a",    ri_a,    pipe[0].ri);
        chk("op_a",    op_a,    pipe[0].op);
        chk("op_b",    op_b,    pipe[0].op);
        chk("wmem_a",  write_mem_a, pipe[1].st);
        chk("rmem_b",  read_mem_b,  pipe[1].ld);
        chk("wreg_a",  write_reg_a, pipe[2].wr);
        chk("lw_a",    lw_a,        pipe[2].ld);
        chk("wbdst_a", wb_dst_a,    pipe[2].dst);
        chk("wreg_b",  write_reg_b, pipe[4].wr);
        chk("lw_b",    lw_b,        pipe[4].ld);
        chk("wbdst_b", wb_dst_b,    pipe[4].dst);
        ew = '0; el = '0; ed = '0;
        for (int k = 0; k < 3; k++) begin
            ew[k] = pipe[k].wr; el[k] = pipe[k].ld; ed[5*k +: 5] = pipe[k].dst;
        end
        chk("stwreg_a", st_wreg_a, ew);
        chk("stlw_a",   st_lw_a,   el);
        chk("stdst_a",  st_dst_a,  ed);
        ew = '0; el = '0; ed = '0;
        for (int k = 0; k < 5; k++) begin
            ew[k] = pipe[k].wr; el[k] = pipe[k].ld; ed[5*k +: 5] = pipe[k].dst;
        end
        chk("stwreg_b", st_wreg_b, ew);
        chk("stlw_b",   st_lw_b,   el);
        chk("stdst_b",  st_dst_b,  ed);
    endtask

    // Drive one cycle at the falling edge, check, then advance the model on the rising edge.
    task automatic cycle(input logic r, input logic [5:0] o, input logic [5:0] f,
                         input logic [4:0] t, input logic [4:0] d, input logic z,
                         input logic s, input logic fl, input logic sp);
        @(negedge clk);
        rst = r; opcode = o; funct = f; rt = t; rd = d; zero = z;
        stall = s; flush = fl; stop = sp;
        #1;
        if (rst) model_clear();
        check_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, OPC_R, F_ADD, 5'd1, 5'd1, 0, 1, 0, 0);
    endtask

    logic [5:0] opc_tab [12] = '{OPC_R, OPC_J, OPC_JAL, OPC_BEQ, OPC_BNE, OPC_ADDI, OPC_SLTI,
                                 OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LW, OPC_SW};
    logic [5:0] fn_tab [10] = '{F_SLL, F_SRL, F_JR, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT};

    initial begin
        logic [5:0] ro, rf;
        logic [4:0] rrt, rrd;
        rst = 1; opcode = OPC_R; funct = F_ADD; rt = 0; rd = 0;
        zero = 0; stall = 0; flush = 0; stop = 0;
        model_clear();

        // Reset from power-up, then idle: nothing valid may appear.
        cycle(1, OPC_R, F_ADD, 5'd1, 5'd2, 0, 0, 0, 0);
        cycle(1, OPC_R, F_ADD, 5'd1, 5'd2, 0, 0, 0, 0);
        idle(3);
        chk("idle_after_rst", st_wreg_b, 0);

        // Latency: ADD rd=5 reaches WB at +3 (1 mem stage) and +5 (3 mem stages).
        cycle(0, OPC_R, F_ADD, 5'd2, 5'd5, 0, 0, 0, 0);
        chk("lat_ex_dst", st_dst_a[4:0], 5);
        chk("lat_ex_wreg", st_wreg_a[0], 1);
        idle(2);
        chk("lat_wb_a_wreg", write_reg_a, 1);
        chk("lat_wb_a_dst", wb_dst_a, 5);
        idle(2);
        chk("lat_wb_b_wreg", write_reg_b, 1);
        chk("lat_wb_b_dst", wb_dst_b, 5);
        idle(3);

        // Load strobe for one cycle at +2, then a store that never writes a register.
        cycle(0, OPC_LW, F_ADD, 5'd7, 5'd0, 0, 0, 0, 0);
        chk("lw_st_lw0", st_lw_a[0], 1);
        idle(1);
        chk("lw_rmem_a", read_mem_a, 1);
        chk("lw_rmem_b", read_mem_b, 1);
        idle(1);
        chk("lw_rmem_once", read_mem_a, 0);
        idle(4);
        cycle(0, OPC_SW, F_ADD, 5'd9, 5'd0, 0, 0, 0, 0);
        idle(1);
        chk("sw_wmem", write_mem_a, 1);
        for (int i = 0; i < 4; i++) begin
            chk("sw_no_wreg", st_wreg_b, 0);
            idle(1);
        end

        // Bubbles: stall, flush, and both together each cost exactly one slot.
        idle(5);
        cycle(0, OPC_LW, F_ADD, 5'd7, 5'd0, 0, 0, 0, 0);
        cycle(0, OPC_R, F_ADD, 5'd2, 5'd4, 0, 1, 0, 0);
        chk("stall_ex_zero", st_wreg_a[0], 0);
        chk("stall_lw_adv", st_lw_a[1], 1);
        cycle(0, OPC_R, F_ADD, 5'd2, 5'd4, 0, 0, 1, 0);
        chk("flush_ex_zero", st_dst_a[4:0], 0);
        chk("flush_lw_adv", st_lw_a[2], 1);
        cycle(0, OPC_R, F_ADD, 5'd2, 5'd4, 0, 1, 1, 0);
        cycle(0, OPC_R, F_ADD, 5'd2, 5'd4, 0, 0, 0, 0);
        chk("stall_flush_single", st_wreg_a, 3'b001);

        // Stop holds LW in mem stage 0 and ADD in WB; stall under stop changes nothing.
        idle(5);
        cycle(0, OPC_R, F_ADD, 5'd2, 5'd5, 0, 0, 0, 0);
        cycle(0, OPC_LW, F_ADD, 5'd7, 5'd0, 0, 0, 0, 0);
        cycle(0, OPC_ORI, F_ADD, 5'd3, 5'd0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, OPC_R, F_ADD, 5'd2, 5'd6, 0, 1, 1, 1);
            chk("stop_rmem", read_mem_a, 1);
            chk("stop_wreg", write_reg_a, 1);
            chk("stop_wbdst", wb_dst_a, 5);
            chk("stop_ex_hold", st_dst_a[4:0], 3);
        end
        idle(1);
        chk("stop_release", read_mem_a, 0);

        // Decode corners.
        idle(5);
        cycle(0, OPC_JAL, F_ADD, 5'd4, 5'd4, 0, 0, 0, 0);
        chk("jal_comb", jal_a, 1);
        idle(2);
        chk("jal_wb_wreg", write_reg_a, 1);
        chk("jal_wb_dst", wb_dst_a, 31);
        cycle(0, OPC_BNE, F_ADD, 5'd4, 5'd4, 0, 0, 0, 0);
        chk("bne_nz_jbeq", jbeq_a, 1);
        cycle(0, OPC_BEQ, F_ADD, 5'd4, 5'd4, 0, 0, 0, 0);
        chk("beq_nz_jbeq", jbeq_a, 0);
        cycle(0, OPC_R, F_ADD, 5'd4, 5'd0, 0, 0, 0, 0);
        chk("add_r0_wreg", st_wreg_a[0], 0);
        cycle(0, OPC_R, F_SLT, 5'd4, 5'd8, 0, 0, 0, 0);
        chk("slt_op", op_a, 5);
        cycle(0, OPC_R, F_NOR, 5'd4, 5'd8, 0, 0, 0, 0);
        chk("nor_op", op_b, 6);

        // Asynchronous reset with a full pipe: outputs clear before the next edge.
        for (int i = 0; i < 6; i++)
            cycle(0, OPC_R, F_ADD, 5'd1, 5'(i + 10), 0, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_async_wreg_b", st_wreg_b, 0);
        chk("rst_async_dst_b", st_dst_b, 0);
        chk("rst_async_wreg_a", write_reg_a, 0);
        model_clear();
        cycle(1, OPC_R, F_ADD, 5'd1, 5'd2, 0, 0, 0, 0);
        idle(2);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 700; i++) begin
            ro  = ($urandom_range(9) == 0) ? 6'($urandom) : opc_tab[$urandom_range(11)];
            rf  = ($urandom_range(9) == 0) ? 6'($urandom) : fn_tab[$urandom_range(9)];
            rrt = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            rrd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            cycle(($urandom_range(63) == 0), ro, rf, rrt, rrd, 1'($urandom),
                  ($urandom_range(5) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
